// File: rtl/bus_store_buffer.sv
// Posted-write buffer between the CPU memory port and bus_master: stores queue in a FIFO, loads wait for it to drain.
// Optional store-to-load forwarding of full-word entries is enabled by defining STORE_BUF_FWD_EN.
module bus_store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    input  logic        we_i,
    input  logic [31:0] data_i,
    input  logic [29:0] addr_i,
    input  logic [3:0]  byte_mask_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        wr_err_o,
    output logic        empty_o,
    output logic        m_en_o,
    output logic        m_we_o,
    output logic [31:0] m_data_o,
    output logic [29:0] m_addr_o,
    output logic [3:0]  m_byte_mask_o,
    input  logic [31:0] m_data_i,
    input  logic        m_valid_i,
    input  logic        m_stall_i,
    input  logic        m_err_i
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   wptr_q, wptr_d;
    logic [PTR_W-1:0]   rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               rd_pend_q, rd_pend_d;
    logic               wr_pend_q, wr_pend_d;
    logic               wr_err_q, wr_err_d;

    logic               is_store_c, is_load_c;
    logic               full_c, nonempty_c;
    logic               push_c, pop_c;
    logic               ld_issue_c, ld_acc_c;
    logic               fwd_hit_c;
    entry_t             head_c;

    assign is_store_c = en_i && we_i;
    assign is_load_c  = en_i && !we_i;
    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign nonempty_c = (count_q != '0);
    assign head_c     = mem_q[rptr_q];

    // Request arbitration: queued stores own the bus; a load passes through only when the FIFO is empty.
    always_comb begin
        push_c        = 1'b0;
        pop_c         = 1'b0;
        ld_issue_c    = 1'b0;
        ld_acc_c      = 1'b0;
        stall_o       = 1'b0;
        m_en_o        = 1'b0;
        m_we_o        = 1'b0;
        m_addr_o      = addr_i;
        m_data_o      = data_i;
        m_byte_mask_o = byte_mask_i;

        push_c     = is_store_c && !full_c;
        pop_c      = nonempty_c && !m_stall_i;
        ld_issue_c = is_load_c && !nonempty_c;
        ld_acc_c   = ld_issue_c && !m_stall_i;

        if (nonempty_c) begin
            m_en_o        = 1'b1;
            m_we_o        = 1'b1;
            m_addr_o      = head_c.addr;
            m_data_o      = head_c.data;
            m_byte_mask_o = head_c.mask;
        end else if (ld_issue_c) begin
            m_en_o = 1'b1;
        end

        if (is_store_c) begin
            stall_o = full_c;
        end else if (is_load_c) begin
            if (fwd_hit_c) begin
                stall_o = 1'b0;
            end else if (nonempty_c) begin
                stall_o = 1'b1;
            end else begin
                stall_o = m_stall_i;
            end
        end
    end

    // Next-state for pointers, occupancy and the pending/error flags.
    always_comb begin
        wptr_d    = wptr_q + PTR_W'(push_c);
        rptr_d    = rptr_q + PTR_W'(pop_c);
        count_d   = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_pend_d = rd_pend_q;
        wr_pend_d = pop_c;
        wr_err_d  = wr_err_q || (wr_pend_q && m_err_i);
        if (ld_acc_c) begin
            rd_pend_d = 1'b1;
        end else if (rd_pend_q && (m_valid_i || m_err_i)) begin
            rd_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            rd_pend_q <= 1'b0;
            wr_pend_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            rd_pend_q <= rd_pend_d;
            wr_pend_q <= wr_pend_d;
            wr_err_q  <= wr_err_d;
        end
    end

    // Entry storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (!rst && push_c) begin
            mem_q[wptr_q] <= '{addr: addr_i, data: data_i, mask: byte_mask_i};
        end
    end

    assign err_o    = rd_pend_q && m_err_i;
    assign wr_err_o = wr_err_q;
    assign empty_o  = !nonempty_c && !wr_pend_q;

`ifdef STORE_BUF_FWD_EN
    logic        fwd_match_c;
    entry_t      fwd_entry_c;
    logic        fwd_valid_q;
    logic [31:0] fwd_data_q;

    // Scan oldest to youngest so the youngest address match is the one kept.
    always_comb begin
        fwd_match_c = 1'b0;
        fwd_entry_c = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            logic [PTR_W-1:0] idx;
            idx = rptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (mem_q[idx].addr == addr_i)) begin
                fwd_match_c = 1'b1;
                fwd_entry_c = mem_q[idx];
            end
        end
    end

    assign fwd_hit_c = is_load_c && fwd_match_c && (fwd_entry_c.mask == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid_q <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            fwd_valid_q <= fwd_hit_c;
            fwd_data_q  <= fwd_entry_c.data;
        end
    end

    assign valid_o = (rd_pend_q && m_valid_i) || fwd_valid_q;
    assign data_o  = fwd_valid_q ? fwd_data_q : m_data_i;
`else
    assign fwd_hit_c = 1'b0;
    assign valid_o   = rd_pend_q && m_valid_i;
    assign data_o    = m_data_i;
`endif

endmodule
